tb_sequencer: RTL and testbench

- Drives stimulus into the DUT and the arithmetic monitor, and scores the monitor's o_event stream.
- Operands come from two LFSRs and are issued one per cycle for a programmed number of tests.
- Monitor warm-up and pipeline latency are masked; mismatches are counted and an overall pass/fail is reported.
- Top-level of the testbench harness: sits between the start/status interface and the DUT + monitor pair.

---
 rtl/tb_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_tb_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/tb_sequencer.sv
// Stimulus sequencer and event scorer for the arithmetic monitor harness: LFSR operands, warm-up/drain masking, error counting.
// Optional capture of the first failing operands/index is enabled by defining TB_SEQ_ERR_CAPTURE_EN.
module tb_sequencer #(
  parameter int unsigned     WIDTH      = 32,
  parameter int unsigned     CNT_WIDTH  = 16,
  parameter int unsigned     WARMUP_CYC = 8,
  parameter int unsigned     EVENT_LAT  = 4,
  parameter logic [WIDTH-1:0] TAPS      = 32'h80200003,
  parameter logic [WIDTH-1:0] SEED      = 32'h1ACEB00C
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [CNT_WIDTH-1:0] i_num_tests,
  input  logic                 i_stop_on_err,
  input  logic                 i_event,
  output logic [WIDTH-1:0]     o_dut_ia,
  output logic [WIDTH-1:0]     o_dut_ib,
  output logic                 o_valid,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [CNT_WIDTH-1:0] o_test_cnt,
`ifdef TB_SEQ_ERR_CAPTURE_EN
  output logic [WIDTH-1:0]     o_err_ia,
  output logic [WIDTH-1:0]     o_err_ib,
  output logic [CNT_WIDTH-1:0] o_err_idx,
`endif
  output logic [CNT_WIDTH-1:0] o_err_cnt
);

  localparam int unsigned WARM_W = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
  localparam int unsigned LAT_W  = (EVENT_LAT > 1) ? $clog2(EVENT_LAT) : 1;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYC - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(EVENT_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_WARMUP, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                 st;
  logic [WIDTH-1:0]       lfsr_a, lfsr_b;
  logic [CNT_WIDTH-1:0]   num_q;
  logic                   stop_q;
  logic [WARM_W-1:0]      warm_cnt;
  logic [LAT_W-1:0]       drain_cnt;
  logic [EVENT_LAT-1:0]   vld_dly;

  logic                   scored_c;
  logic                   to_done_c;
  logic [CNT_WIDTH-1:0]   err_nxt_c;
  logic [CNT_WIDTH-1:0]   test_nxt_c;
  logic [WIDTH-1:0]       step_a_c, step_b_c;

`ifdef TB_SEQ_ERR_CAPTURE_EN
  logic [WIDTH-1:0]       cap_a_dly [EVENT_LAT];
  logic [WIDTH-1:0]       cap_b_dly [EVENT_LAT];
  logic [CNT_WIDTH-1:0]   cap_i_dly [EVENT_LAT];
`endif

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : '0);
  endfunction

  // Scoring and exit conditions; only events aligned with a counted issue are scored.
  always_comb begin
    scored_c   = 1'b0;
    to_done_c  = 1'b0;
    step_a_c   = lfsr_step(lfsr_a);
    step_b_c   = lfsr_step(lfsr_b);
    test_nxt_c = o_test_cnt + CNT_WIDTH'(1);
    if (st == S_WARMUP || st == S_RUN || st == S_DRAIN)
      scored_c = i_event & vld_dly[EVENT_LAT-1];
    err_nxt_c = (scored_c && o_err_cnt != '1) ? o_err_cnt + CNT_WIDTH'(1) : o_err_cnt;
    case (st)
      S_WARMUP: to_done_c = (warm_cnt == WARM_LAST) && (num_q == '0);
      S_RUN:    to_done_c = stop_q & scored_c;
      S_DRAIN:  to_done_c = (stop_q & scored_c) || (drain_cnt == LAT_LAST);
      default:  to_done_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= S_IDLE;
      lfsr_a     <= SEED;
      lfsr_b     <= ~SEED;
      o_dut_ia   <= '0;
      o_dut_ib   <= '0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_pass     <= 1'b0;
      o_test_cnt <= '0;
      o_err_cnt  <= '0;
      num_q      <= '0;
      stop_q     <= 1'b0;
      warm_cnt   <= '0;
      drain_cnt  <= '0;
      vld_dly    <= '0;
`ifdef TB_SEQ_ERR_CAPTURE_EN
      o_err_ia   <= '0;
      o_err_ib   <= '0;
      o_err_idx  <= '0;
`endif
    end else begin
      vld_dly <= EVENT_LAT'({vld_dly, o_valid});
`ifdef TB_SEQ_ERR_CAPTURE_EN
      // Operands and index ride alongside the valid delay so the scored event sees its own stimulus.
      cap_a_dly[0] <= o_dut_ia;
      cap_b_dly[0] <= o_dut_ib;
      cap_i_dly[0] <= o_test_cnt;
      for (int k = 1; k < EVENT_LAT; k++) begin
        cap_a_dly[k] <= cap_a_dly[k-1];
        cap_b_dly[k] <= cap_b_dly[k-1];
        cap_i_dly[k] <= cap_i_dly[k-1];
      end
      if (scored_c && o_err_cnt == '0) begin
        o_err_ia  <= cap_a_dly[EVENT_LAT-1];
        o_err_ib  <= cap_b_dly[EVENT_LAT-1];
        o_err_idx <= cap_i_dly[EVENT_LAT-1];
      end
`endif
      case (st)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            st         <= S_WARMUP;
            lfsr_a     <= lfsr_step(SEED);
            lfsr_b     <= lfsr_step(~SEED);
            o_dut_ia   <= lfsr_step(SEED);
            o_dut_ib   <= lfsr_step(~SEED);
            o_test_cnt <= '0;
            o_err_cnt  <= '0;
            num_q      <= i_num_tests;
            stop_q     <= i_stop_on_err;
            warm_cnt   <= '0;
            vld_dly    <= '0;
            o_busy     <= 1'b1;
            o_done     <= 1'b0;
            o_pass     <= 1'b0;
`ifdef TB_SEQ_ERR_CAPTURE_EN
            o_err_ia   <= '0;
            o_err_ib   <= '0;
            o_err_idx  <= '0;
`endif
          end
        end
        S_WARMUP: begin
          lfsr_a    <= step_a_c;
          lfsr_b    <= step_b_c;
          o_dut_ia  <= step_a_c;
          o_dut_ib  <= step_b_c;
          o_err_cnt <= err_nxt_c;
          warm_cnt  <= warm_cnt + WARM_W'(1);
          if (warm_cnt == WARM_LAST && num_q != '0) begin
            st      <= S_RUN;
            o_valid <= 1'b1;
          end
        end
        S_RUN: begin
          lfsr_a     <= step_a_c;
          lfsr_b     <= step_b_c;
          o_dut_ia   <= step_a_c;
          o_dut_ib   <= step_b_c;
          o_err_cnt  <= err_nxt_c;
          o_test_cnt <= test_nxt_c;
          if (test_nxt_c == num_q) begin
            st        <= S_DRAIN;
            o_valid   <= 1'b0;
            drain_cnt <= '0;
          end
        end
        S_DRAIN: begin
          o_err_cnt <= err_nxt_c;
          drain_cnt <= drain_cnt + LAT_W'(1);
        end
        default: st <= S_IDLE;
      endcase
      // Common exit into DONE; overrides any RUN/DRAIN transition taken above.
      if (to_done_c) begin
        st      <= S_DONE;
        o_valid <= 1'b0;
        o_busy  <= 1'b0;
        o_done  <= 1'b1;
        o_pass  <= (err_nxt_c == '0);
      end
    end
  end

endmodule

// File: tb/tb_tb_sequencer.sv
// Directed bench for tb_sequencer: run lengths, event masking, stop-on-error, LFSR operands, mid-run reset.
module tb_tb_sequencer;

  localparam int unsigned W   = 32;
  localparam int unsigned CW  = 16;
  localparam int unsigned WU  = 8;
  localparam int unsigned LAT = 4;
  localparam logic [W-1:0] TAPS = 32'h80200003;
  localparam logic [W-1:0] SEED = 32'h1ACEB00C;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_start;
  logic [CW-1:0] i_num_tests;
  logic          i_stop_on_err;
  logic          i_event;
  logic [W-1:0]  o_dut_ia, o_dut_ib;
  logic          o_valid, o_busy, o_done, o_pass;
  logic [CW-1:0] o_test_cnt, o_err_cnt;
`ifdef TB_SEQ_ERR_CAPTURE_EN
  logic [W-1:0]  o_err_ia, o_err_ib;
  logic [CW-1:0] o_err_idx;
`endif

  int total = 0;
  int bad   = 0;

  tb_sequencer dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_num_tests(i_num_tests),
    .i_stop_on_err(i_stop_on_err), .i_event(i_event),
    .o_dut_ia(o_dut_ia), .o_dut_ib(o_dut_ib), .o_valid(o_valid), .o_busy(o_busy),
    .o_done(o_done), .o_pass(o_pass), .o_test_cnt(o_test_cnt),
`ifdef TB_SEQ_ERR_CAPTURE_EN
    .o_err_ia(o_err_ia), .o_err_ib(o_err_ib), .o_err_idx(o_err_idx),
`endif
    .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] step_n(input logic [W-1:0] v, input int n);
    logic [W-1:0] r = v;
    for (int i = 0; i < n; i++) r = (r >> 1) ^ (r[0] ? TAPS : '0);
    return r;
  endfunction

  // mode 0: no events, 1: event always high, 2: one pulse LAT cycles after valid index pidx
  task automatic run(input int n, input bit stop, input int mode, input int pidx, input bit poke,
                     output int busy_cyc, output int pulse_cyc, output int done_cyc,
                     output int op_err, output logic [W-1:0] first_ia);
    int cyc = 0;
    int vcnt = 0;
    int pend = -1;
    busy_cyc = 0; pulse_cyc = -1; op_err = 0;
    i_num_tests = CW'(n); i_stop_on_err = stop; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    first_ia = o_dut_ia;
    while (!o_done && cyc < 500) begin
      if (o_busy) busy_cyc++;
      i_event = (mode == 1) || (cyc == pend);
      if (cyc == pend) pulse_cyc = cyc;
      if (o_valid) begin
        if (o_dut_ia !== step_n(SEED, 1 + WU + vcnt) || o_dut_ib !== step_n(~SEED, 1 + WU + vcnt))
          op_err++;
        if (mode == 2 && vcnt == pidx) pend = cyc + LAT;
        vcnt++;
      end
      i_start = poke && (cyc == 12);
      @(posedge clk); #1;
      cyc++;
    end
    i_event = 1'b0; i_start = 1'b0;
    done_cyc = cyc;
    chk("run_terminates", o_done, 1);
  endtask

  int bc, pc, dc, oe, guard;
  logic [W-1:0] fia, fia0;

  initial begin
    reset = 1'b1; i_start = 1'b0; i_num_tests = '0; i_stop_on_err = 1'b0; i_event = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy", o_busy, 0);      chk("rst_done", o_done, 0);
    chk("rst_valid", o_valid, 0);    chk("rst_pass", o_pass, 0);
    chk("rst_test", o_test_cnt, 0);  chk("rst_err", o_err_cnt, 0);
    chk("rst_ia", o_dut_ia, 0);      chk("rst_ib", o_dut_ib, 0);

    // clean run, with an ignored start pulse mid-run
    run(10, 0, 0, 0, 1, bc, pc, dc, oe, fia0);
    chk("t1_busy_cyc", bc, WU + 10 + LAT);
    chk("t1_pass", o_pass, 1);       chk("t1_test", o_test_cnt, 10);
    chk("t1_err", o_err_cnt, 0);     chk("t1_ops", oe, 0);
    chk("t1_first_ia", fia0, step_n(SEED, 1));
    chk("t1_busy_low", o_busy, 0);

    // event stuck high: only the 10 aligned events are scored
    run(10, 0, 1, 0, 0, bc, pc, dc, oe, fia);
    chk("t2_err", o_err_cnt, 10);    chk("t2_pass", o_pass, 0);
    chk("t2_test", o_test_cnt, 10);  chk("t2_first_ia", fia, fia0);

    // stop on error after 3rd valid's event
    run(10, 1, 2, 2, 0, bc, pc, dc, oe, fia);
    chk("t3_done_next", dc, pc + 1);
    chk("t3_err", o_err_cnt, 1);     chk("t3_test", o_test_cnt, 3 + LAT);
    chk("t3_pass", o_pass, 0);

    // zero tests: warm-up only
    run(0, 0, 0, 0, 0, bc, pc, dc, oe, fia);
    chk("t4_busy_cyc", bc, WU);      chk("t4_test", o_test_cnt, 0);
    chk("t4_pass", o_pass, 1);

    // reset mid-run at test count 5
    i_num_tests = CW'(10); i_stop_on_err = 1'b0; i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    guard = 0;
    while (o_test_cnt != 5 && guard < 100) begin @(posedge clk); #1; guard++; end
    chk("t5_reach5", o_test_cnt, 5);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("t5_busy", o_busy, 0);       chk("t5_valid", o_valid, 0);
    chk("t5_done", o_done, 0);       chk("t5_test", o_test_cnt, 0);
    chk("t5_ia", o_dut_ia, 0);
    run(10, 0, 0, 0, 0, bc, pc, dc, oe, fia);
    chk("t5_busy_cyc", bc, WU + 10 + LAT);
    chk("t5_rerun_test", o_test_cnt, 10); chk("t5_rerun_pass", o_pass, 1);
    chk("t5_ops", oe, 0);            chk("t5_first_ia", fia, step_n(SEED, 1));

`ifdef TB_SEQ_ERR_CAPTURE_EN
    run(10, 0, 2, 6, 0, bc, pc, dc, oe, fia);
    chk("cap_err", o_err_cnt, 1);
    chk("cap_idx", o_err_idx, 6);
    chk("cap_ia", o_err_ia, step_n(SEED, 1 + WU + 6));
    chk("cap_ib", o_err_ib, step_n(~SEED, 1 + WU + 6));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
